// File: rtl/periph_resp_pkg.sv
// Shared types and helpers for the peripheral-bus responder: FSM states,
// response opcodes, index map helpers and byte-lane merge.
package periph_resp_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    localparam logic OPC_OK  = 1'b0;
    localparam logic OPC_ERR = 1'b1;
    localparam int   IDX_W   = 6;

    function automatic logic [IDX_W-1:0] IDX_STATUS(input int n);
        return IDX_W'(n);
    endfunction

    function automatic logic [IDX_W-1:0] IDX_CYCLE(input int n);
        return IDX_W'(n + 1);
    endfunction

    // Replace only the byte lanes whose enable is set.
    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_val[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/periph_resp_regfile.sv
// Byte-enable scratch registers plus a free-running, writable CYCLE counter,
// with a combinational read port that also decodes the read-only status word.
module periph_resp_regfile
    import periph_resp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int N_REGS     = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         we,
    input  logic [IDX_W-1:0]             widx,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [BE_WIDTH-1:0]          be,
    input  logic [IDX_W-1:0]             ridx,
    input  logic [DATA_WIDTH-1:0]        status,
    output logic [DATA_WIDTH-1:0]        rdata,
    output logic                         hit,
    output logic                         ro,
    output logic [N_REGS*DATA_WIDTH-1:0] regs
);

    logic [DATA_WIDTH-1:0] regs_q [N_REGS];
    logic [DATA_WIDTH-1:0] cycle_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_REGS; i++) regs_q[i] <= '0;
            cycle_q <= '0;
        end else begin
            for (int i = 0; i < N_REGS; i++) begin
                if (we && widx == IDX_W'(i)) regs_q[i] <= be_merge(regs_q[i], wdata, be);
            end
            // A write to CYCLE takes the place of that cycle's increment.
            if (we && widx == IDX_CYCLE(N_REGS)) cycle_q <= be_merge(cycle_q, wdata, be);
            else                                 cycle_q <= cycle_q + 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        hit   = 1'b0;
        ro    = 1'b0;
        for (int i = 0; i < N_REGS; i++) begin
            if (ridx == IDX_W'(i)) begin
                rdata = regs_q[i];
                hit   = 1'b1;
            end
        end
        if (ridx == IDX_STATUS(N_REGS)) begin
            rdata = status;
            hit   = 1'b1;
            ro    = 1'b1;
        end
        if (ridx == IDX_CYCLE(N_REGS)) begin
            rdata = cycle_q;
            hit   = 1'b1;
        end
    end

    always_comb begin
        regs = '0;
        for (int i = 0; i < N_REGS; i++) regs[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end

endmodule

// File: rtl/periph_bus_responder.sv
// Target end of the peripheral bus: grants requests, answers after a fixed
// LATENCY with one r_valid pulse per grant, backed by periph_resp_regfile.
module periph_bus_responder
    import periph_resp_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 5,
    parameter int N_REGS     = 8,
    parameter int LATENCY    = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         req_i,
    input  logic [ADDR_WIDTH-1:0]        add_i,
    input  logic                         wen_i,
    input  logic [DATA_WIDTH-1:0]        wdata_i,
    input  logic [BE_WIDTH-1:0]          be_i,
    input  logic [ID_WIDTH-1:0]          id_i,
    output logic                         gnt_o,
    output logic                         r_valid_o,
    output logic [DATA_WIDTH-1:0]        r_rdata_o,
    output logic                         r_opc_o,
    output logic [ID_WIDTH-1:0]          r_id_o,
    input  logic [DATA_WIDTH-1:0]        status_i,
    output logic [N_REGS*DATA_WIDTH-1:0] regs_o
);

    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    state_e                state;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] rf_rdata;
    logic                  rf_hit;
    logic                  rf_ro;
    logic                  we;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_opc;
    logic [DATA_WIDTH-1:0] pend_rdata;
    logic                  pend_opc;
    logic [ID_WIDTH-1:0]   pend_id;
    logic                  unused_addr;

    assign idx         = add_i[7:2];
    assign unused_addr = ^{add_i[ADDR_WIDTH-1:8], add_i[1:0]};

    assign gnt_o = req_i & (state == IDLE || state == RESP);
    assign we    = gnt_o & ~wen_i & rf_hit & ~rf_ro;

    // Reads are sampled here, before any write in the same cycle commits.
    assign rsp_rdata = (wen_i && rf_hit) ? rf_rdata : '0;
    assign rsp_opc   = (!rf_hit || (!wen_i && rf_ro)) ? OPC_ERR : OPC_OK;

    periph_resp_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .BE_WIDTH   (BE_WIDTH),
        .N_REGS     (N_REGS)
    ) u_regfile (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .we     (we),
        .widx   (idx),
        .wdata  (wdata_i),
        .be     (be_i),
        .ridx   (idx),
        .status (status_i),
        .rdata  (rf_rdata),
        .hit    (rf_hit),
        .ro     (rf_ro),
        .regs   (regs_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            cnt        <= '0;
            pend_rdata <= '0;
            pend_opc   <= OPC_OK;
            pend_id    <= '0;
            r_valid_o  <= 1'b0;
            r_rdata_o  <= '0;
            r_opc_o    <= OPC_OK;
            r_id_o     <= '0;
        end else begin
            r_valid_o <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (gnt_o) begin
                        if (LATENCY == 1) begin
                            state     <= RESP;
                            r_valid_o <= 1'b1;
                            r_rdata_o <= rsp_rdata;
                            r_opc_o   <= rsp_opc;
                            r_id_o    <= id_i;
                        end else begin
                            state      <= WAIT;
                            cnt        <= CNT_W'(LATENCY - 2);
                            pend_rdata <= rsp_rdata;
                            pend_opc   <= rsp_opc;
                            pend_id    <= id_i;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state     <= RESP;
                        r_valid_o <= 1'b1;
                        r_rdata_o <= pend_rdata;
                        r_opc_o   <= pend_opc;
                        r_id_o    <= pend_id;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_periph_bus_responder.sv
// Bench for periph_bus_responder: three instances (LATENCY 1, 3, 4) sharing
// request fields, with a per-instance response scoreboard.
module tb_periph_bus_responder;

    localparam logic [31:0] STATUS = 32'h1234_5678;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] erd;
        logic        eop;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        opc;
        logic [4:0]  id;
        int          due;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [2:0]   req;
    logic [31:0]  add;
    logic         wen;
    logic [31:0]  wdata;
    logic [3:0]   be;
    logic [4:0]   id;
    logic [31:0]  status;
    logic [2:0]   gnt;
    logic [2:0]   vld;
    logic [2:0]   opc;
    logic [31:0]  rdat [3];
    logic [4:0]   rid  [3];
    logic [255:0] regs [3];

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   lat [3] = '{1, 3, 4};
    exp_t sbq [3][$];
    vec_t tbl [13];

    periph_bus_responder #(.LATENCY(1)) u_lat1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .add_i(add), .wen_i(wen),
        .wdata_i(wdata), .be_i(be), .id_i(id), .gnt_o(gnt[0]), .r_valid_o(vld[0]),
        .r_rdata_o(rdat[0]), .r_opc_o(opc[0]), .r_id_o(rid[0]), .status_i(status),
        .regs_o(regs[0])
    );

    periph_bus_responder #(.LATENCY(3)) u_lat3 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .add_i(add), .wen_i(wen),
        .wdata_i(wdata), .be_i(be), .id_i(id), .gnt_o(gnt[1]), .r_valid_o(vld[1]),
        .r_rdata_o(rdat[1]), .r_opc_o(opc[1]), .r_id_o(rid[1]), .status_i(status),
        .regs_o(regs[1])
    );

    periph_bus_responder #(.LATENCY(4)) u_lat4 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[2]), .add_i(add), .wen_i(wen),
        .wdata_i(wdata), .be_i(be), .id_i(id), .gnt_o(gnt[2]), .r_valid_o(vld[2]),
        .r_rdata_o(rdat[2]), .r_opc_o(opc[2]), .r_id_o(rid[2]), .status_i(status),
        .regs_o(regs[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
    endtask

    // Response monitor: every r_valid must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                if (vld[k]) begin
                    if (sbq[k].size() == 0) begin
                        fail_now($sformatf("unexpected_rvalid_u%0d", k));
                    end else begin
                        exp_t e;
                        e = sbq[k].pop_front();
                        chk($sformatf("rdata_u%0d_id%0d", k, e.id), rdat[k], e.rdata);
                        chk($sformatf("opc_u%0d_id%0d", k, e.id), 32'(opc[k]), 32'(e.opc));
                        chk($sformatf("rid_u%0d_id%0d", k, e.id), 32'(rid[k]), 32'(e.id));
                        chk($sformatf("latency_u%0d_id%0d", k, e.id), 32'(cyc), 32'(e.due));
                    end
                end
            end
        end
    end

    task automatic issue(input int k, input logic [31:0] a, input logic w,
                         input logic [31:0] wd, input logic [3:0] b, input logic [4:0] i,
                         input logic [31:0] erd, input logic eop, output int waited);
        exp_t e;
        waited = 0;
        add = a; wen = w; wdata = wd; be = b; id = i;
        req = 3'b000;
        req[k] = 1'b1;
        @(negedge clk);
        while (!gnt[k] && waited < 16) begin
            @(negedge clk);
            waited++;
        end
        if (!gnt[k]) begin
            fail_now($sformatf("grant_timeout_u%0d_id%0d", k, i));
        end else begin
            e.rdata = erd;
            e.opc   = eop;
            e.id    = i;
            e.due   = cyc + lat[k];
            sbq[k].push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        req = 3'b000;
        while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0) fail_now("drain");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          waited;
        logic [31:0] exp_regs [8];

        tbl[0]  = '{32'h0000_0008, 1'b0, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
        tbl[1]  = '{32'h0000_0008, 1'b1, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{32'h0000_0020, 1'b1, 32'h0000_0000, 4'hF, STATUS,        1'b0};
        tbl[3]  = '{32'h0000_0020, 1'b0, 32'hFFFF_0000, 4'hF, 32'h0000_0000, 1'b1};
        tbl[4]  = '{32'h0000_0020, 1'b1, 32'h0000_0000, 4'hF, STATUS,        1'b0};
        tbl[5]  = '{32'h0000_0034, 1'b1, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};
        tbl[6]  = '{32'h0000_0034, 1'b0, 32'hAAAA_AAAA, 4'hF, 32'h0000_0000, 1'b1};
        tbl[7]  = '{32'h0000_0014, 1'b0, 32'h1122_3344, 4'h0, 32'h0000_0000, 1'b0};
        tbl[8]  = '{32'h0000_0014, 1'b1, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b0};
        tbl[9]  = '{32'h0000_0014, 1'b0, 32'h5566_7788, 4'hA, 32'h0000_0000, 1'b0};
        tbl[10] = '{32'h0000_0014, 1'b1, 32'h0000_0000, 4'hF, 32'h5500_7700, 1'b0};
        tbl[11] = '{32'h0000_00FC, 1'b1, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};
        tbl[12] = '{32'hFFFF_FF0B, 1'b1, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF, 1'b0};

        rst_n = 1'b0;
        req = 3'b000; add = '0; wen = 1'b1; wdata = '0; be = '0; id = '0;
        status = STATUS;
        repeat (3) @(negedge clk);
        chk("reset_rvalid", 32'(vld[0]), 32'h0);
        chk("reset_rdata", rdat[0], 32'h0);
        chk("reset_opc", 32'(opc[0]), 32'h0);
        chk("reset_rid", 32'(rid[0]), 32'h0);
        chk("reset_regs_lo", regs[0][31:0], 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // LATENCY=1 vector table, issued back to back.
        for (int t = 0; t < 13; t++) begin
            issue(0, tbl[t].addr, tbl[t].wen, tbl[t].wdata, tbl[t].be, 5'(t),
                  tbl[t].erd, tbl[t].eop, waited);
            chk($sformatf("b2b_grant_wait_%0d", t), 32'(waited), 32'h0);
        end
        drain();
        for (int r = 0; r < 8; r++) exp_regs[r] = 32'h0;
        exp_regs[2] = 32'hDEAD_BEEF;
        exp_regs[5] = 32'h5500_7700;
        for (int r = 0; r < 8; r++) chk($sformatf("regs_u0_r%0d", r), regs[0][r*32 +: 32], exp_regs[r]);
        repeat (2) @(negedge clk);
        chk("hold_rvalid", 32'(vld[0]), 32'h0);
        chk("hold_rdata", rdat[0], 32'hDEAD_BEEF);
        chk("hold_rid", 32'(rid[0]), 32'd12);
        @(posedge clk);
        #1;

        // CYCLE counter load, then wrap seen by back-to-back reads.
        issue(0, 32'h24, 1'b0, 32'hFFFF_FFFE, 4'hF, 5'd20, 32'h0, 1'b0, waited);
        issue(0, 32'h24, 1'b1, 32'h0, 4'hF, 5'd21, 32'hFFFF_FFFE, 1'b0, waited);
        issue(0, 32'h24, 1'b1, 32'h0, 4'hF, 5'd22, 32'hFFFF_FFFF, 1'b0, waited);
        issue(0, 32'h24, 1'b1, 32'h0, 4'hF, 5'd23, 32'h0000_0000, 1'b0, waited);
        issue(0, 32'h24, 1'b1, 32'h0, 4'hF, 5'd24, 32'h0000_0001, 1'b0, waited);
        drain();

        // LATENCY=3: partial-byte write, next request stalls through WAIT.
        issue(1, 32'h0, 1'b0, 32'hFFFF_FFFF, 4'b0101, 5'd7, 32'h0, 1'b0, waited);
        issue(1, 32'h0, 1'b1, 32'h0, 4'hF, 5'd8, 32'h00FF_00FF, 1'b0, waited);
        chk("lat3_stall_cycles", 32'(waited), 32'd2);
        drain();
        chk("lat3_reg0", regs[1][31:0], 32'h00FF_00FF);

        // LATENCY=4: reset while a response is pending.
        issue(2, 32'h4, 1'b0, 32'hCAFE_F00D, 4'hF, 5'd1, 32'h0, 1'b0, waited);
        drain();
        chk("lat4_reg1_written", regs[2][63:32], 32'hCAFE_F00D);
        issue(2, 32'h4, 1'b1, 32'h0, 4'hF, 5'd2, 32'hCAFE_F00D, 1'b0, waited);
        req = 3'b000;
        @(negedge clk);
        rst_n = 1'b0;
        sbq[2].delete();
        repeat (2) @(negedge clk);
        chk("midrst_rvalid", 32'(vld[2]), 32'h0);
        chk("midrst_rdata", rdat[2], 32'h0);
        chk("midrst_opc", 32'(opc[2]), 32'h0);
        chk("midrst_rid", 32'(rid[2]), 32'h0);
        chk("midrst_reg1", regs[2][63:32], 32'h0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_no_rvalid", 32'(vld[2]), 32'h0);
        @(posedge clk);
        #1;
        issue(2, 32'h4, 1'b1, 32'h0, 4'hF, 5'd9, 32'h0, 1'b0, waited);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
